// File: rtl/rv32_alu_dec.sv
// rv32_alu_dec: RV32 integer ALU decode stage with a two-entry (main + skid) handshake buffer.
//
// Ports:
//   clk_in        - clock, all state updates on the rising edge
//   rst_n_in      - asynchronous active-low reset, released synchronously by the system
//   in_valid_in   - upstream offers an instruction bundle
//   in_ready_out  - registered; low only while both buffer entries are full
//   instr_in, pc_in, rs1_data_in, rs2_data_in - instruction word, its PC, register read data
//   out_valid_out - decoded bundle available
//   out_ready_in  - ALU stage accepts the bundle
//   op_1_out, op_2_out - ALU operands
//   opcode_out    - {alt, funct3}; alt selects SUB (000) or SRA (101)
//   rd_out        - destination register
//   illegal_out   - bundle could not be decoded (operands, opcode and rd forced to zero)
//
// Configuration: define RV32_ALU_DEC_UPPER_EN to decode LUI and AUIPC; otherwise they are illegal.
module rv32_alu_dec (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        in_valid_in,
    output logic        in_ready_out,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    output logic        out_valid_out,
    input  logic        out_ready_in,
    output logic [31:0] op_1_out,
    output logic [31:0] op_2_out,
    output logic [3:0]  opcode_out,
    output logic [4:0]  rd_out,
    output logic        illegal_out
);
    typedef struct packed {
        logic [31:0] op_1;
        logic [31:0] op_2;
        logic [3:0]  opcode;
        logic [4:0]  rd;
        logic        illegal;
    } bundle_t;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       op_legal;
    logic       imm_legal;
    logic       unused_fields;
    bundle_t    dec;

    assign opc = instr_in[6:0];
    assign f3  = instr_in[14:12];
    assign f7  = instr_in[31:25];
    // rs1 index is resolved by the register file; pc is only needed for AUIPC
    assign unused_fields = ^{instr_in[19:15], pc_in};

    assign op_legal  = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
    // shift-immediates reuse funct7 bits of the immediate as an encoding field
    assign imm_legal = (f3 == 3'b001) ? (f7 == 7'b0000000) :
                       (f3 == 3'b101) ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1;

    always_comb begin
        dec         = '0;
        dec.illegal = 1'b1;
        case (opc)
            7'b0110011: if (op_legal) begin
                dec.op_1    = rs1_data_in;
                dec.op_2    = rs2_data_in;
                dec.opcode  = {instr_in[30], f3};
                dec.rd      = instr_in[11:7];
                dec.illegal = 1'b0;
            end
            7'b0010011: if (imm_legal) begin
                dec.op_1    = rs1_data_in;
                dec.op_2    = {{20{instr_in[31]}}, instr_in[31:20]};
                dec.opcode  = {(f3 == 3'b101) & instr_in[30], f3};
                dec.rd      = instr_in[11:7];
                dec.illegal = 1'b0;
            end
`ifdef RV32_ALU_DEC_UPPER_EN
            7'b0110111: begin
                dec.op_2    = {instr_in[31:12], 12'b0};
                dec.rd      = instr_in[11:7];
                dec.illegal = 1'b0;
            end
            7'b0010111: begin
                dec.op_1    = pc_in;
                dec.op_2    = {instr_in[31:12], 12'b0};
                dec.rd      = instr_in[11:7];
                dec.illegal = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    bundle_t main_q, main_d, skid_q, skid_d;
    logic    main_v_q, main_v_d, skid_v_q, skid_v_d, ready_q, ready_d;
    logic    acc, drn;

    assign acc = in_valid_in && ready_q;
    assign drn = main_v_q && out_ready_in;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (!main_v_q || drn) begin
            // main frees up: refill from skid first to keep order
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = acc;
                if (acc) skid_d = dec;
            end else begin
                main_v_d = acc;
                if (acc) main_d = dec;
            end
        end else if (acc) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
        ready_d = !skid_v_d;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            ready_q  <= ready_d;
        end
    end

    assign in_ready_out  = ready_q;
    assign out_valid_out = main_v_q;
    assign op_1_out      = main_q.op_1;
    assign op_2_out      = main_q.op_2;
    assign opcode_out    = main_q.opcode;
    assign rd_out        = main_q.rd;
    assign illegal_out   = main_q.illegal;
endmodule
